// File: rtl/pins_test_pkg.sv
// Shared definitions for the pin-test monitor.
//   pin_mode_t      : LED display mode selector
//   DEF_* constants : default parameter values for the top and the per-pin filter
package pins_test_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_STICKY = 2'd3
    } pin_mode_t;

    localparam int DEF_N_IN            = 2;
    localparam int DEF_LED_W           = 8;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/pins_test_monitor_debounce.sv
// One pin's input path: synchroniser chain, debounce counter, filtered level
// and a rising-edge pulse registered together with the filtered level.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   pin      : raw asynchronous pin
//   filt     : debounced level
//   rise     : one-cycle pulse in the cycle filt first shows 1
module pin_debounce
    import pins_test_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DB_W            = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic filt,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [DB_W-1:0]        count_reg;
    logic                   filt_reg;
    logic                   rise_reg;
    logic                   sync;
    logic                   accept;

    assign sync = sync_reg[SYNC_STAGES-1];

    // The new level is taken on the edge where the counter already shows
    // DEBOUNCE_CYCLES-1 differing cycles and the level still differs.
    assign accept = (sync != filt_reg) && (count_reg == DB_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= '0;
            count_reg <= '0;
            filt_reg  <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
            rise_reg <= accept & sync;
            if (sync == filt_reg) begin
                count_reg <= '0;
            end else if (accept) begin
                filt_reg  <= sync;
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + DB_W'(1);
            end
        end
    end

    assign filt = filt_reg;
    assign rise = rise_reg;

endmodule

// File: rtl/pins_test_monitor.sv
// Pin-test monitor: N_IN pins are synchronised and debounced, then shown on
// LED_W LEDs in one of four modes (direct level, toggle, edge count, sticky).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   pins_in  : raw asynchronous pins
//   mode     : 0 DIRECT, 1 TOGGLE, 2 COUNT, 3 STICKY
//   clear    : pulse clearing toggle, count and sticky state
//   leds     : registered LED drive, channel i owns leds[(i+1)*G-1 : i*G]
//   filt     : debounced levels
//   rise     : rising-edge pulses of filt
module pins_test_monitor
    import pins_test_pkg::*;
#(
    parameter int N_IN            = DEF_N_IN,
    parameter int LED_W           = DEF_LED_W,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DB_W            = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  pins_in,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic [LED_W-1:0] leds,
    output logic [N_IN-1:0]  filt,
    output logic [N_IN-1:0]  rise
);

    localparam int G = LED_W / N_IN;

    generate
        if (LED_W % N_IN != 0) begin : g_bad_led_w
            $error("LED_W must be a multiple of N_IN");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
            $error("DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic [N_IN-1:0]  tog_reg;
    logic [N_IN-1:0]  stk_reg;
    logic [LED_W-1:0] cnt_reg;
    logic [LED_W-1:0] leds_reg;
    logic [LED_W-1:0] leds_next;
    logic [LED_W-1:0] direct_leds;
    logic [LED_W-1:0] tog_leds;
    logic [LED_W-1:0] stk_leds;
    pin_mode_t        mode_sel;

    assign mode_sel = pin_mode_t'(mode);

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_chan
            pin_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .DB_W            (DB_W)
            ) u_db (
                .clk  (clk),
                .rst  (rst),
                .pin  (pins_in[gi]),
                .filt (filt[gi]),
                .rise (rise[gi])
            );

            assign direct_leds[gi*G +: G] = {G{filt[gi]}};
            assign tog_leds[gi*G +: G]    = {G{tog_reg[gi]}};
            assign stk_leds[gi*G +: G]    = {G{stk_reg[gi]}};
        end
    endgenerate

    // Mode state always tracks the edges, whatever is being displayed, so
    // switching modes never loses history. clear takes priority over a
    // coincident edge.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tog_reg <= '0;
            stk_reg <= '0;
            cnt_reg <= '0;
        end else begin
            tog_reg <= tog_reg ^ rise;
            stk_reg <= stk_reg | rise;
            cnt_reg <= cnt_reg + LED_W'($countones(rise));
        end
    end

    always_comb begin
        leds_next = direct_leds;
        case (mode_sel)
            MODE_DIRECT: leds_next = direct_leds;
            MODE_TOGGLE: leds_next = tog_leds;
            MODE_COUNT:  leds_next = cnt_reg;
            MODE_STICKY: leds_next = stk_leds;
            default:     leds_next = direct_leds;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_reg <= '0;
        end else begin
            leds_reg <= leds_next;
        end
    end

    assign leds = leds_reg;

endmodule

// File: tb/tb_pins_test_monitor.sv
// Self-checking bench for pins_test_monitor (N_IN=2, LED_W=8, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). A window-based reference model predicts leds/filt/rise
// every cycle into a scoreboard queue; a monitor pops and compares. Directed
// scenarios add explicit checks against fixed expected values.
module tb_pins_test_monitor;

    localparam int N  = 2;
    localparam int L  = 8;
    localparam int S  = 2;
    localparam int D  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] pins_in = '0;
    logic [1:0]   mode = 2'd0;
    logic         clear = 1'b0;
    logic [L-1:0] leds;
    logic [N-1:0] filt;
    logic [N-1:0] rise;

    int n_checks = 0;
    int n_fail   = 0;

    pins_test_monitor #(
        .N_IN            (N),
        .LED_W           (L),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pins_in (pins_in),
        .mode    (mode),
        .clear   (clear),
        .leds    (leds),
        .filt    (filt),
        .rise    (rise)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A pin level reaches the filter S edges after it is sampled. A channel
    // accepts a new level when the last D synchronised samples all differ
    // from its current filtered level.
    logic [N-1:0] m_delay [S];
    logic [N-1:0] m_hist [$];
    logic [N-1:0] m_filt = '0, m_rise = '0, m_tog = '0, m_stk = '0;
    logic [L-1:0] m_cnt = '0, m_leds = '0;
    logic [L+2*N-1:0] sb_q [$];

    function automatic logic [L-1:0] spread(input logic [N-1:0] v);
        logic [L-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++)
            for (int b = 0; b < L / N; b++)
                r[c * (L / N) + b] = v[c];
        return r;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] sync_now, new_filt;
        logic [L-1:0] new_leds;
        bit ok;
        if (rst) begin
            for (int k = 0; k < S; k++) m_delay[k] = '0;
            m_hist = {};
            for (int k = 0; k < D; k++) m_hist.push_back('0);
            m_filt = '0; m_rise = '0; m_tog = '0; m_stk = '0;
            m_cnt = '0; m_leds = '0;
        end else begin
            sync_now = m_delay[S-1];
            m_hist.push_back(sync_now);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            new_filt = m_filt;
            for (int c = 0; c < N; c++) begin
                ok = 1;
                foreach (m_hist[k]) if (m_hist[k][c] == m_filt[c]) ok = 0;
                if (ok) new_filt[c] = sync_now[c];
            end
            case (mode)
                2'd0:    new_leds = spread(m_filt);
                2'd1:    new_leds = spread(m_tog);
                2'd2:    new_leds = m_cnt;
                default: new_leds = spread(m_stk);
            endcase
            if (clear) begin
                m_tog = '0; m_stk = '0; m_cnt = '0;
            end else begin
                m_tog = m_tog ^ m_rise;
                m_stk = m_stk | m_rise;
                m_cnt = m_cnt + L'($countones(m_rise));
            end
            m_rise = new_filt & ~m_filt;
            m_filt = new_filt;
            m_leds = new_leds;
            for (int k = S - 1; k > 0; k--) m_delay[k] = m_delay[k-1];
            m_delay[0] = pins_in;
        end
        sb_q.push_back({m_leds, m_filt, m_rise});
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [L+2*N-1:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if ({leds, filt, rise} !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got leds=%h filt=%b rise=%b, required leds=%h filt=%b rise=%b",
                         $time, leds, filt, rise, e[L+2*N-1:2*N], e[2*N-1:N], e[N-1:0]);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s: %0h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_pulses(input int n, input int ch, inout int pulses);
        repeat (n) begin
            @(negedge clk);
            pulses += int'(rise[ch]);
        end
    endtask

    task automatic press(input logic [N-1:0] m);
        pins_in = m;
        step(8);
        pins_in = '0;
        step(8);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int p;
        step(3);
        check("reset_leds", 32'(leds), 32'h00);
        check("reset_filt_rise", 32'({filt, rise}), 32'h0);
        rst = 1'b0;

        // DIRECT latency and group mapping
        pins_in = 2'b01;
        step(6);
        check("direct_01_before", 32'(leds), 32'h00);
        step(1);
        check("direct_01_at7", 32'(leds), 32'h0F);
        pins_in = 2'b11;
        step(7);
        check("direct_11", 32'(leds), 32'hFF);
        pins_in = 2'b10;
        step(6);
        check("direct_10_before", 32'(leds), 32'hFF);
        step(1);
        check("direct_10_at7", 32'(leds), 32'hF0);
        rst = 1'b1;
        pins_in = 2'b00;
        step(1);
        check("rst_clears_leds", 32'(leds), 32'h00);
        rst = 1'b0;
        step(8);

        // Glitch rejection
        p = 0;
        pins_in = 2'b01;
        step_pulses(3, 0, p);
        pins_in = 2'b00;
        step_pulses(12, 0, p);
        check("glitch_rise_pulses", 32'(p), 32'd0);
        check("glitch_filt", 32'(filt), 32'h0);
        p = 0;
        pins_in = 2'b01;
        step_pulses(10, 0, p);
        check("accept_rise_pulses", 32'(p), 32'd1);
        check("accept_filt", 32'(filt), 32'h1);
        pins_in = 2'b00;
        step(10);

        // TOGGLE
        mode = 2'd1;
        pulse_clear();
        step(1);
        check("toggle_cleared", 32'(leds), 32'h00);
        for (int i = 0; i < 3; i++) press(2'b10);
        check("toggle_three", 32'(leds), 32'hF0);
        press(2'b10);
        check("toggle_four", 32'(leds), 32'h00);

        // COUNT
        mode = 2'd2;
        pulse_clear();
        step(1);
        for (int i = 0; i < 5; i++) press(2'b11);
        check("count_five_double", 32'(leds), 32'h0A);
        pulse_clear();
        step(1);
        for (int i = 0; i < 128; i++) begin
            press(2'b11);
            if (i == 126) check("count_127_double", 32'(leds), 32'hFE);
        end
        check("count_wrap", 32'(leds), 32'h00);
        pulse_clear();
        pins_in = 2'b11;
        step(6);
        check("coincident_rise", 32'(rise), 32'h3);
        pulse_clear();
        step(2);
        check("clear_beats_edge", 32'(leds), 32'h00);
        pins_in = 2'b00;
        step(10);
        check("fall_not_counted", 32'(leds), 32'h00);

        // STICKY and mode switching
        mode = 2'd0;
        pulse_clear();
        step(2);
        press(2'b01);
        mode = 2'd3;
        step(2);
        check("sticky_pin0", 32'(leds), 32'h0F);
        mode = 2'd2;
        step(2);
        check("count_after_switch", 32'(leds), 32'h01);
        pulse_clear();
        step(1);
        check("clear_next_cycle", 32'(leds), 32'h00);

        // Reset in the middle of a debounce
        mode = 2'd0;
        step(4);
        pins_in = 2'b01;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        p = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            p += int'(rise[0]);
            if (i == 6) check("mid_rst_before", 32'(leds), 32'h00);
            if (i == 7) check("mid_rst_at7", 32'(leds), 32'h0F);
        end
        check("mid_rst_rise_pulses", 32'(p), 32'd1);

        // Randomised traffic, checked by the scoreboard only
        for (int i = 0; i < 400; i++) begin
            pins_in = N'($urandom);
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom);
            clear = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            step(1);
            clear = 1'b0;
            rst   = 1'b0;
            step($urandom_range(0, 9));
        end

        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
